uart_rx: RTL and testbench
==========================

# uart_rx

Avalon UART slave receive path: recovers 8N1-style serial frames from the asynchronous `rxd_i` line using 16x oversampling derived from the same `clk_div` divisor that drives the UART baud clock generator. It converts the serial line back into parallel bytes and presents each byte through a single-entry valid/ready holding register. The Avalon register file reads that register, and the block reports framing and overrun errors as single-cycle status pulses.

## Interface

- `DATA_BITS`, default 8: data bits per frame, LSB first, 5..8.
- `OVERSAMPLE`, default 16: ticks per bit period; must be an even number ≥ 4.

- `clk_i`, in, 1: system clock. Everything in the block is synchronous to this clock.
- `reset`, in, 1: synchronous, active-high reset. This is the only clock and reset in the block.
- `clk_div`, in, 32: oversample tick period minus one, in `clk_i` cycles. A tick fires every `clk_div`+1 cycles.
- `rxd_i`, in, 1: asynchronous serial line; idle level is high.
- `data_o`, out, `DATA_BITS`: received byte in the holding register.
- `valid_o`, out, 1: the holding register is full.
- `ready_i`, in, 1: the consumer accepts the byte; a transfer occurs when `valid_o` and `ready_i` are both high.
- `frame_err_o`, out, 1: qualified by `valid_o`. High means the stop bit of the held byte sampled low.
- `overrun_o`, out, 1: one-cycle pulse. A completed byte was dropped because the holding register was full.

## Operation

**Input synchronizer**
- `rxd_i` passes through a 2-flop synchronizer to produce `rxd_s`.
- Both flops reset to 1.
- All logic uses `rxd_s` only.

**Tick generator**
- 32-bit counter `tcnt`.
- `tick` is asserted when `tcnt == div_q`; `tcnt` then returns to 0, otherwise it increments.
- `div_q` latches `clk_div` at start detection and stays constant for the whole frame.
- A `clk_div` change takes effect at the next frame.
- `clk_div = 0` gives a tick on every cycle.
- `tcnt` is forced to 0 on the start edge, which phase-aligns sampling to the edge.

**Sample counter**
- 4-bit (log2 `OVERSAMPLE`) counter `scnt`, advanced on `tick`.

**Bit counter**
- Counter `bcnt`, counting 0..`DATA_BITS`-1.

**FSM**
- HUNT (reset state)
  - Waits for `rxd_s == 1` on any cycle, then goes to IDLE.
  - This prevents a line held low through reset from being taken as a start bit.
- IDLE
  - When `rxd_s` goes from 1 to 0: clear `tcnt` and `scnt`, latch `div_q`, go to START.
- START
  - On the tick where `scnt` reaches `OVERSAMPLE`/2-1 (mid start bit), sample `rxd_s`.
  - If it is 0: clear `scnt` and `bcnt`, go to DATA.
  - If it is 1: false start, go to IDLE with no output.
- DATA
  - Each time `scnt` reaches `OVERSAMPLE`-1 (mid bit), shift `rxd_s` into the MSB of the shift register (right shift), giving LSB-first order.
  - After sample `DATA_BITS`-1, go to STOP.
- STOP
  - At the mid stop bit, complete the byte (see holding register below) with `ferr = !rxd_s`.
  - If `rxd_s == 1`, go to IDLE.
  - If `rxd_s == 0` (framing error or break), go to HUNT.

**Holding register, on byte completion**
- If `!valid_o`, or `valid_o && ready_i` in the same cycle:
  - Load `data_o` and `frame_err_o`; `valid_o` is 1.
  - A simultaneous accept plus load never raises `overrun_o`.
- If `valid_o && !ready_i`:
  - The new byte is discarded and the old byte and its flag are kept.
  - `overrun_o` pulses high for 1 cycle.
- Accept with no completion: `valid_o` goes to 0 on the next cycle; `data_o` holds its last value.

**Reset**
- `reset` high at any time, including mid-frame, aborts any frame in progress.
- Next edge values:
  - state HUNT
  - `valid_o`, `frame_err_o`, `overrun_o` all 0
  - `data_o` 0
  - `tcnt`, `scnt`, `bcnt` all 0
  - synchronizer flops 1

## Timing

- Synchronizer latency: 2 `clk_i` cycles from a `rxd_i` edge to `rxd_s`.
- Start detection occurs 1 cycle after the `rxd_s` fall.
- Let T = (`div_q`+1)·`OVERSAMPLE` cycles, i.e. one bit period.
- Mid start-bit sample: T/2 after detection.
- Data bit k is sampled at T/2 + (k+1)·T after detection.
- Stop bit is sampled at T/2 + (`DATA_BITS`+1)·T after detection.
- `valid_o`, `data_o` and `frame_err_o` update on the clock edge following the stop sample.
- `overrun_o` is asserted on that same edge.
- Worked case, `clk_div=3`, defaults (T=64):
  - byte valid 3+32+576+1 = 612 cycles after the `rxd_i` fall (±1 for synchronizer phase).
- Back-to-back frames are supported. A new start edge is accepted on the first cycle in IDLE, which is T/2 before the nominal stop-bit end, so the block tolerates up to about 3% baud mismatch.
- `ready_i` may be held high permanently; a byte is then accepted in the cycle after `valid_o` rises.

## Test plan

- **Basic frame:** `clk_div=3`, send 0xA5 as 8N1 at 64 cycles/bit with `ready_i=1` -> one `valid_o` pulse with `data_o=0xA5`, `frame_err_o=0`, 612±1 cycles after the start edge. Repeat for 0x00, 0xFF and back-to-back 0x55,0xAA with no idle gap -> both bytes received.
- **Backpressure and overrun:** `ready_i=0`, send 0x12 then 0x34 -> `data_o` stays 0x12, `valid_o=1`, `overrun_o` pulses for 1 cycle at the 0x34 stop sample. Then raise `ready_i` exactly in the completion cycle of a third byte 0x56 -> `data_o=0x56`, `valid_o` stays 1, no overrun.
- **Framing error:** send 0x3C with the stop bit driven 0 for 2 bit times, then 1 -> `data_o=0x3C` with `frame_err_o=1`; FSM in HUNT until the line goes high. The next frame 0x81 is received cleanly.
- **False start:** 20-cycle low glitch on `rxd_i` with `clk_div=3` (shorter than T/2=32) -> no `valid_o`, FSM back in IDLE. The following real frame 0x7E is received correctly.
- **Reset behaviour:** assert `reset` for 1 cycle at data bit 4 of a frame -> all outputs 0 on the next edge and no byte delivered for that frame. Hold `rxd_i` low through and after reset -> no reception until the line goes high. A subsequent 0xC3 is received.
- **Minimum divisor and divisor change:** `clk_div=0` (16 cycles/bit), send 0x96 -> byte delivered at 3+8+144+1 cycles. Change `clk_div` from 0 to 7 mid-frame -> current frame still decoded at the old rate; the next frame is decoded at 128 cycles/bit.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled serial receiver with a single-entry valid/ready
// holding register, framing-error flag and overrun pulse.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_i,
    input  logic                 reset,
    input  logic [31:0]          clk_div,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        HUNT  = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic [1:0]           sync_vld_q;
    logic                 rxd_s;
    logic [31:0]          tcnt_q;
    logic [31:0]          div_q;
    logic [SW-1:0]        scnt_q;
    logic [BW-1:0]        bcnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 done_q;
    logic                 stop_ferr_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 overrun_q;

    logic tick;
    logic mid_start;
    logic mid_bit;
    logic start_det;
    logic start_ok;
    logic bit_sample;
    logic stop_sample;
    logic load;

    assign rxd_s     = sync_q[1];
    assign tick      = (tcnt_q == div_q);
    assign mid_start = tick && (scnt_q == S_HALF);
    assign mid_bit   = tick && (scnt_q == S_LAST);

    // Two-flop synchronizer; sync_vld_q marks when the flops hold real line
    // samples rather than their reset value, so HUNT cannot be fooled by a
    // line that is still low after reset.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            sync_q     <= 2'b11;
            sync_vld_q <= 2'b00;
        end else begin
            sync_q     <= {sync_q[0], rxd_i};
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset) state_q <= HUNT;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:  if (sync_vld_q[1] && rxd_s) state_d = IDLE;
            IDLE:  if (!rxd_s) state_d = START;
            START: if (mid_start) state_d = rxd_s ? IDLE : DATA;
            DATA:  if (mid_bit && (bcnt_q == B_LAST)) state_d = STOP;
            STOP:  if (mid_bit) state_d = rxd_s ? IDLE : HUNT;
            default: state_d = HUNT;
        endcase
    end

    // FSM output decode: datapath strobes for each sampling point.
    always_comb begin
        start_det   = 1'b0;
        start_ok    = 1'b0;
        bit_sample  = 1'b0;
        stop_sample = 1'b0;
        case (state_q)
            IDLE:  start_det   = !rxd_s;
            START: start_ok    = mid_start && !rxd_s;
            DATA:  bit_sample  = mid_bit;
            STOP:  stop_sample = mid_bit;
            default: ;
        endcase
    end

    // Tick, sample and bit counters; divisor is frozen per frame at the start edge.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            tcnt_q <= '0;
            div_q  <= '0;
            scnt_q <= '0;
            bcnt_q <= '0;
        end else begin
            if (start_det || tick) tcnt_q <= '0;
            else                   tcnt_q <= tcnt_q + 32'd1;

            if (start_det) div_q <= clk_div;

            if (start_det || start_ok)   scnt_q <= '0;
            else if (tick)               scnt_q <= (scnt_q == S_LAST) ? '0 : scnt_q + SW'(1);

            if (start_ok)                bcnt_q <= '0;
            else if (bit_sample)         bcnt_q <= (bcnt_q == B_LAST) ? '0 : bcnt_q + BW'(1);
        end
    end

    // Shift register (LSB first) and a one-cycle completion stage after the stop sample.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            shift_q     <= '0;
            done_q      <= 1'b0;
            stop_ferr_q <= 1'b0;
        end else begin
            if (bit_sample)  shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
            done_q <= stop_sample;
            if (stop_sample) stop_ferr_q <= !rxd_s;
        end
    end

    assign load = done_q && (!valid_q || ready_i);

    // Holding register: load on completion when empty or being drained,
    // otherwise drop the new byte and pulse overrun.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= done_q && valid_q && !ready_i;
            if (load) begin
                data_q  <= shift_q;
                ferr_q  <= stop_ferr_q;
                valid_q <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and randomized frames against a timing/byte model.
module tb_uart_rx;

    localparam int DBITS = 8;
    localparam int OVS   = 16;
    localparam int EW    = 41;  // {expected cycle[40:9], ferr[8], data[7:0]}
    localparam int NV    = 9;

    logic        clk_i = 1'b0;
    logic        reset;
    logic [31:0] clk_div;
    logic        rxd_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        frame_err_o;
    logic        overrun_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ovr_cnt = 0;
    int last_ovr_cyc = -1;
    int xfer_cnt = 0;
    bit sb_en = 1'b0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         stop_val;
        int         stop_len;
        int         gap;
        logic [7:0] exp_data;
        bit         exp_ferr;
        int         exp_lat;
    } vec_t;

    vec_t vecs[NV];

    uart_rx #(.DATA_BITS(DBITS), .OVERSAMPLE(OVS)) dut (
        .clk_i(clk_i), .reset(reset), .clk_div(clk_div), .rxd_i(rxd_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .frame_err_o(frame_err_o), .overrun_o(overrun_o)
    );

    // clock and cycle counter
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_win(input string name, input int got, input int exp);
        total++;
        if (got < exp - 1 || got > exp + 1) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d(+-1)", name, got, exp);
        end
    endtask

    // Reference timing: detection 3 cycles after the line fall, stop sample
    // at T/2 + (DBITS+1)*T after detection, byte visible one edge later.
    function automatic int model_lat(input int div);
        int t;
        t = (div + 1) * OVS;
        return 3 + t / 2 + (DBITS + 1) * t + 1;
    endfunction

    // driver tasks (entered and left at posedge+1)
    task automatic drive(input bit v, input int n);
        rxd_i = v;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int div, input bit stop_val, input int stop_len);
        int cpb;
        cpb = (div + 1) * OVS;
        clk_div = 32'(div);
        drive(1'b0, cpb);
        for (int i = 0; i < DBITS; i++) drive(d[i], cpb);
        drive(stop_val, cpb * stop_len);
        rxd_i = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int fall;
        fall = cyc;
        exp_q.push_back({32'(fall + v.exp_lat), v.exp_ferr, v.exp_data});
        send_frame(v.data, v.div, v.stop_val, v.stop_len);
        drive(1'b1, v.gap);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        vec_t v;
        int base, t34, t56, xb, fall;

        vecs[0] = '{8'hA5, 3, 1'b1, 1, 10, 8'hA5, 1'b0, 612};
        vecs[1] = '{8'h00, 3, 1'b1, 1, 10, 8'h00, 1'b0, 612};
        vecs[2] = '{8'hFF, 3, 1'b1, 1, 10, 8'hFF, 1'b0, 612};
        vecs[3] = '{8'h55, 3, 1'b1, 1,  0, 8'h55, 1'b0, 612};
        vecs[4] = '{8'hAA, 3, 1'b1, 1, 10, 8'hAA, 1'b0, 612};
        vecs[5] = '{8'h3C, 3, 1'b0, 2, 10, 8'h3C, 1'b1, 612};
        vecs[6] = '{8'h81, 3, 1'b1, 1, 10, 8'h81, 1'b0, 612};
        vecs[7] = '{8'h96, 0, 1'b1, 1, 10, 8'h96, 1'b0, 156};
        vecs[8] = '{8'h0F, 1, 1'b1, 1,  5, 8'h0F, 1'b0, 308};

        // scoreboard / monitor
        fork
            begin : mon
                logic [EW-1:0] e;
                forever begin
                    @(negedge clk_i);
                    if (overrun_o) begin
                        ovr_cnt++;
                        last_ovr_cyc = cyc;
                    end
                    if (valid_o && ready_i) begin
                        xfer_cnt++;
                        if (sb_en) begin
                            if (exp_q.size() == 0) begin
                                total++;
                                bad++;
                                $display("FAIL unexpected_byte: got=%0h exp=none", data_o);
                            end else begin
                                e = exp_q.pop_front();
                                chk("rx_data", data_o, 32'(e[7:0]));
                                chk("rx_ferr", frame_err_o, 32'(e[8]));
                                chk_win("rx_time", cyc, int'(e[40:9]));
                            end
                        end
                    end
                end
            end
        join_none

        // reset
        reset = 1'b1; rxd_i = 1'b1; ready_i = 1'b1; clk_div = 32'd3;
        @(posedge clk_i);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_ferr", frame_err_o, 0);
        chk("rst_ovr", overrun_o, 0);
        repeat (2) begin @(posedge clk_i); #1; end
        reset = 1'b0;
        drive(1'b1, 10);
        sb_en = 1'b1;

        // table-driven frames
        for (int i = 0; i < NV; i++) run_vec(vecs[i]);
        wait_drain(3000);

        // randomized frames against the model
        for (int i = 0; i < 10; i++) begin
            bit err;
            v.data     = 8'($urandom_range(0, 255));
            v.div      = $urandom_range(0, 3);
            err        = ($urandom_range(0, 3) == 0);
            v.stop_val = !err;
            v.stop_len = err ? $urandom_range(1, 2) : 1;
            v.gap      = err ? $urandom_range(4, 12) : $urandom_range(0, 8);
            v.exp_data = v.data;
            v.exp_ferr = err;
            v.exp_lat  = model_lat(v.div);
            run_vec(v);
        end
        wait_drain(3000);

        // backpressure and overrun
        sb_en = 1'b0;
        ready_i = 1'b0;
        base = ovr_cnt;
        send_frame(8'h12, 3, 1'b1, 1);
        drive(1'b1, 10);
        chk("bp_valid1", valid_o, 1);
        chk("bp_data1", data_o, 32'h12);
        t34 = cyc;
        send_frame(8'h34, 3, 1'b1, 1);
        drive(1'b1, 10);
        chk("bp_valid2", valid_o, 1);
        chk("bp_data2", data_o, 32'h12);
        chk("bp_ovr_count", ovr_cnt - base, 1);
        chk("bp_ovr_cycle", last_ovr_cyc, t34 + 612);
        t56 = cyc;
        fork
            send_frame(8'h56, 3, 1'b1, 1);
            begin
                repeat (611) @(posedge clk_i);
                #1;
                ready_i = 1'b1;
                @(posedge clk_i);
                #1;
                ready_i = 1'b0;
            end
        join
        drive(1'b1, 10);
        chk("acc_load_valid", valid_o, 1);
        chk("acc_load_data", data_o, 32'h56);
        chk("acc_load_no_ovr", ovr_cnt - base, 1);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        chk("accept_valid", valid_o, 0);
        chk("accept_data_hold", data_o, 32'h56);

        // reset mid-frame with a held byte
        send_frame(8'h5A, 3, 1'b1, 1);
        drive(1'b1, 10);
        chk("hold_5a", data_o, 32'h5A);
        fork
            send_frame(8'hF0, 3, 1'b1, 1);
            begin
                repeat (350) @(posedge clk_i);
                #1;
                reset = 1'b1;
                @(posedge clk_i);
                #1;
                chk("midrst_valid", valid_o, 0);
                chk("midrst_data", data_o, 0);
                chk("midrst_ferr", frame_err_o, 0);
                chk("midrst_ovr", overrun_o, 0);
                reset = 1'b0;
            end
        join
        drive(1'b1, 100);
        chk("aborted_frame", valid_o, 0);

        // line held low through and after reset
        rxd_i = 1'b0;
        reset = 1'b1;
        @(posedge clk_i);
        #1;
        reset = 1'b0;
        drive(1'b0, 300);
        chk("low_after_reset", valid_o, 0);
        drive(1'b1, 20);
        ready_i = 1'b1;
        sb_en = 1'b1;
        v = '{8'hC3, 3, 1'b1, 1, 10, 8'hC3, 1'b0, 612};
        run_vec(v);
        wait_drain(2000);

        // false start glitch
        xb = xfer_cnt;
        clk_div = 32'd3;
        drive(1'b0, 20);
        drive(1'b1, 100);
        chk("false_start", xfer_cnt - xb, 0);
        v = '{8'h7E, 3, 1'b1, 1, 10, 8'h7E, 1'b0, 612};
        run_vec(v);
        wait_drain(2000);

        // divisor change mid-frame
        fall = cyc;
        exp_q.push_back({32'(fall + 156), 1'b0, 8'h3A});
        fork
            send_frame(8'h3A, 0, 1'b1, 1);
            begin
                repeat (50) @(posedge clk_i);
                #1;
                clk_div = 32'd7;
            end
        join
        drive(1'b1, 10);
        v = '{8'hE7, 7, 1'b1, 1, 10, 8'hE7, 1'b0, 1220};
        run_vec(v);
        wait_drain(3000);

        chk("overrun_total", ovr_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
